// File: rtl/vga_scan_doubler.sv
// Scan doubler: captures a low-rate source raster into a small ring of line
// buffers and replays it as a programmable VGA raster with double/scanline/blank modes.
module vga_scan_doubler #(
  parameter int unsigned COLOUR_W    = 3,
  parameter int unsigned SRC_WIDTH   = 640,
  parameter int unsigned SRC_LINES   = 256,
  parameter int unsigned SRC_V_START = 24,
  parameter int unsigned LINES_LOG2  = 3,
  parameter int unsigned H_DISP      = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_PULSE     = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_DISP      = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_PULSE     = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned H_SRC_START = 0,
  parameter int unsigned V_OFFSET    = 0,
  parameter bit          SYNC_POL    = 1'b0
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                READ_en,
  input  logic                WRITE_en,
  input  logic                VSYNC,
  input  logic                HSYNC,
  input  logic [COLOUR_W-1:0] RGB,
  input  logic [1:0]          MODE,
  output logic                VGA_HSYNC,
  output logic                VGA_VSYNC,
  output logic [COLOUR_W-1:0] VGA_RGB,
  output logic                VGA_DE,
  output logic                VGA_NEWLINE,
  output logic                VGA_NEWFRAME
);

  localparam int unsigned H_TOTAL  = H_DISP + H_FRONT + H_PULSE + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISP + V_FRONT + V_PULSE + V_BACK;
  localparam int unsigned HS_START = H_DISP + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_PULSE;
  localparam int unsigned VS_START = V_DISP + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_PULSE;
  localparam int unsigned H_W      = $clog2(H_TOTAL);
  localparam int unsigned V_W      = $clog2(V_TOTAL);
  localparam int unsigned RING     = 1 << LINES_LOG2;
  localparam int unsigned CI_W     = $clog2(SRC_WIDTH);
  localparam int unsigned COL_W    = CI_W + 1;
  localparam int unsigned LINE_W   = $clog2(SRC_V_START + SRC_LINES + 1) + 1;

  // ---------------- VGA timing generator ----------------
  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (READ_en) begin
      if (32'(h_q) == H_TOTAL - 1) begin
        h_d = '0;
        v_d = (32'(v_q) == V_TOTAL - 1) ? '0 : v_q + V_W'(1);
      end else begin
        h_d = h_q + H_W'(1);
      end
    end
  end

  // ---------------- read stage 0: address and blanking ----------------
  logic                  in_disp, blank;
  logic [V_W-1:0]        v_rel;
  logic [31:0]           src_line, src_col;
  logic                  hs_act, vs_act, nl_act, nf_act;

  always_comb begin
    in_disp  = (32'(h_q) < H_DISP) && (32'(v_q) < V_DISP);
    v_rel    = v_q - V_W'(V_OFFSET);
    src_line = 32'(v_rel) >> 1;
    src_col  = 32'(h_q) + H_SRC_START;
    blank    = !in_disp || (32'(v_q) < V_OFFSET) || (src_line >= SRC_LINES) ||
               (src_col >= SRC_WIDTH) || ((MODE == 2'b01) && v_rel[0]) || MODE[1];
    hs_act   = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
    vs_act   = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);
    nl_act   = (32'(h_q) == H_TOTAL - 1);
    nf_act   = nl_act && (32'(v_q) == V_TOTAL - 1);
  end

  // ---------------- read stage 1: address register ----------------
  logic                  rd_blank_q, rd_blank_d;
  logic [LINES_LOG2-1:0] rd_line_q, rd_line_d;
  logic [CI_W-1:0]       rd_col_q, rd_col_d;
  logic                  hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d, nl1_q, nl1_d, nf1_q, nf1_d;

  always_comb begin
    rd_blank_d = rd_blank_q;
    rd_line_d  = rd_line_q;
    rd_col_d   = rd_col_q;
    hs1_d      = hs1_q;
    vs1_d      = vs1_q;
    de1_d      = de1_q;
    nl1_d      = nl1_q;
    nf1_d      = nf1_q;
    if (READ_en) begin
      rd_blank_d = blank;
      rd_line_d  = blank ? '0 : LINES_LOG2'(src_line);
      rd_col_d   = blank ? '0 : CI_W'(src_col);
      hs1_d      = hs_act;
      vs1_d      = vs_act;
      de1_d      = in_disp;
      nl1_d      = nl_act;
      nf1_d      = nf_act;
    end
  end

  // ---------------- line ring buffer ----------------
  logic [COLOUR_W-1:0]   line_buf [RING][SRC_WIDTH];
  logic                  wa_en_q, wa_en_d;
  logic [LINES_LOG2-1:0] wa_line_q, wa_line_d;
  logic [CI_W-1:0]       wa_col_q, wa_col_d;
  logic [COLOUR_W-1:0]   wa_data_q, wa_data_d;

  // Nonblocking write: a same-edge read of this address sees the old data.
  always_ff @(posedge CLK) begin
    if (wa_en_q) line_buf[wa_line_q][wa_col_q] <= wa_data_q;
  end

  // ---------------- read stage 2: RAM register and aligned syncs ----------------
  logic [COLOUR_W-1:0] rgb_q, rgb_d;
  logic                hs_q, hs_d, vs_q, vs_d, de_q, de_d, nl_q, nl_d, nf_q, nf_d;

  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    de_d  = de_q;
    nl_d  = nl_q;
    nf_d  = nf_q;
    if (READ_en) begin
      rgb_d = rd_blank_q ? '0 : line_buf[rd_line_q][rd_col_q];
      hs_d  = hs1_q ? SYNC_POL : ~SYNC_POL;
      vs_d  = vs1_q ? SYNC_POL : ~SYNC_POL;
      de_d  = de1_q;
      nl_d  = nl1_q;
      nf_d  = nf1_q;
    end
  end

  // ---------------- source write path ----------------
  logic              vs_prev_q, vs_prev_d, hs_prev_q, hs_prev_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              vs_fall, hs_fall, pix_ok;
  logic [31:0]       idx;

  always_comb begin
    vs_prev_d = vs_prev_q;
    hs_prev_d = hs_prev_q;
    line_d    = line_q;
    col_d     = col_q;
    wa_en_d   = 1'b0;
    wa_line_d = wa_line_q;
    wa_col_d  = wa_col_q;
    wa_data_d = wa_data_q;
    vs_fall   = vs_prev_q && !VSYNC;
    hs_fall   = hs_prev_q && !HSYNC;
    idx       = 32'(line_q) - SRC_V_START;
    pix_ok    = (32'(line_q) >= SRC_V_START) && (idx < SRC_LINES) && (32'(col_q) < SRC_WIDTH);
    if (WRITE_en) begin
      vs_prev_d = VSYNC;
      hs_prev_d = HSYNC;
      if (vs_fall) begin
        line_d = '0;
        col_d  = '0;
      end else if (hs_fall) begin
        col_d = '0;
        if (line_q != '1) line_d = line_q + LINE_W'(1);
      end else begin
        if (pix_ok) begin
          wa_en_d   = 1'b1;
          wa_line_d = LINES_LOG2'(idx);
          wa_col_d  = CI_W'(col_q);
          wa_data_d = RGB;
        end
        if (col_q != '1) col_d = col_q + COL_W'(1);
      end
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      h_q        <= '0;
      v_q        <= '0;
      rd_blank_q <= 1'b1;
      rd_line_q  <= '0;
      rd_col_q   <= '0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      de1_q      <= 1'b0;
      nl1_q      <= 1'b0;
      nf1_q      <= 1'b0;
      rgb_q      <= '0;
      hs_q       <= ~SYNC_POL;
      vs_q       <= ~SYNC_POL;
      de_q       <= 1'b0;
      nl_q       <= 1'b0;
      nf_q       <= 1'b0;
      vs_prev_q  <= 1'b0;
      hs_prev_q  <= 1'b0;
      line_q     <= '0;
      col_q      <= '0;
      wa_en_q    <= 1'b0;
      wa_line_q  <= '0;
      wa_col_q   <= '0;
      wa_data_q  <= '0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      rd_blank_q <= rd_blank_d;
      rd_line_q  <= rd_line_d;
      rd_col_q   <= rd_col_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      de1_q      <= de1_d;
      nl1_q      <= nl1_d;
      nf1_q      <= nf1_d;
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      de_q       <= de_d;
      nl_q       <= nl_d;
      nf_q       <= nf_d;
      vs_prev_q  <= vs_prev_d;
      hs_prev_q  <= hs_prev_d;
      line_q     <= line_d;
      col_q      <= col_d;
      wa_en_q    <= wa_en_d;
      wa_line_q  <= wa_line_d;
      wa_col_q   <= wa_col_d;
      wa_data_q  <= wa_data_d;
    end
  end

  assign VGA_HSYNC    = hs_q;
  assign VGA_VSYNC    = vs_q;
  assign VGA_RGB      = rgb_q;
  assign VGA_DE       = de_q;
  assign VGA_NEWLINE  = nl_q;
  assign VGA_NEWFRAME = nf_q;

endmodule
